// File: rtl/branch_hazard_ctrl_pkg.sv
// rtl/branch_hazard_ctrl_pkg.sv - shared types and constants for the branch hazard controller
// Contents: FSM state encoding, default register address width, zero-register index.
package branch_hazard_ctrl_pkg;

    localparam int ADDR_W_DEFAULT = 5;

    // Register 0 is hard-wired to zero, so a write to it never produces a hazard.
    localparam int REG_ZERO = 0;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        STALL   = 2'd1,
        RESOLVE = 2'd2
    } state_t;

    // Counter value loaded on detection: stall cycles still owed after the detection cycle.
    function automatic logic [1:0] stall_cnt_init(input int total_stalls);
        return 2'(total_stalls - 1);
    endfunction

endpackage

// File: rtl/branch_hazard_ctrl_if.sv
// rtl/branch_hazard_ctrl_if.sv - ID-stage branch hazard bundle (pipeline inputs and control outputs)
// master: pipeline side, drives branch/producer info and reads stall/redirect controls.
// slave : hazard controller, reads branch/producer info and drives stall/redirect controls.
interface branch_hazard_ctrl_if
    import branch_hazard_ctrl_pkg::*;
#(
    parameter int ADDR_W = ADDR_W_DEFAULT
) ();

    logic              branch_ID;
    logic              branch_ne_ID;
    logic [ADDR_W-1:0] rs_ID;
    logic [ADDR_W-1:0] rt_ID;
    logic              regWrite_EX;
    logic              memRead_EX;
    logic [ADDR_W-1:0] regFileWriteAddr_EX;
    logic              regWrite_MEM;
    logic              memRead_MEM;
    logic [ADDR_W-1:0] regFileWriteAddr_MEM;
    logic              regEqulityC;
    logic              stall_PC;
    logic              stall_IFID;
    logic              bubble_IDEX;
    logic              pcSrc;
    logic              flush_IFID;

    modport master (
        output branch_ID, branch_ne_ID, rs_ID, rt_ID,
        output regWrite_EX, memRead_EX, regFileWriteAddr_EX,
        output regWrite_MEM, memRead_MEM, regFileWriteAddr_MEM,
        output regEqulityC,
        input  stall_PC, stall_IFID, bubble_IDEX, pcSrc, flush_IFID
    );

    modport slave (
        input  branch_ID, branch_ne_ID, rs_ID, rt_ID,
        input  regWrite_EX, memRead_EX, regFileWriteAddr_EX,
        input  regWrite_MEM, memRead_MEM, regFileWriteAddr_MEM,
        input  regEqulityC,
        output stall_PC, stall_IFID, bubble_IDEX, pcSrc, flush_IFID
    );

endinterface

// File: rtl/branch_hazard_ctrl_hazard_match.sv
// rtl/branch_hazard_ctrl_hazard_match.sv - combinational load-producer vs branch-consumer compare
// Ports: branch (consumer present), reg_write/mem_read/wr_addr (producer), rs/rt (consumer
// sources) -> hit (consumer must wait for the load data).
module branch_hazard_ctrl_hazard_match
    import branch_hazard_ctrl_pkg::*;
#(
    parameter int ADDR_W = ADDR_W_DEFAULT
) (
    input  logic              branch,
    input  logic              reg_write,
    input  logic              mem_read,
    input  logic [ADDR_W-1:0] wr_addr,
    input  logic [ADDR_W-1:0] rs,
    input  logic [ADDR_W-1:0] rt,
    output logic              hit
);

    always_comb begin
        hit = branch & reg_write & mem_read
            & (wr_addr != ADDR_W'(REG_ZERO))
            & ((wr_addr == rs) | (wr_addr == rt));
    end

endmodule

// File: rtl/branch_hazard_ctrl.sv
// rtl/branch_hazard_ctrl.sv - ID-stage branch hazard controller for load producers in EX/MEM
// Ports: clk, rst_n (sync, active low), bus (branch_hazard_ctrl_if.slave).
// Optional (BRANCH_HAZARD_STATS_EN): stall_count, taken_count saturating 16-bit counters.
// Stalls PC/IF-ID and bubbles ID/EX while a load feeding the branch is in flight, then
// resolves the branch from regEqulityC; outputs are combinational from state and inputs.
module branch_hazard_ctrl
    import branch_hazard_ctrl_pkg::*;
#(
    parameter int ADDR_W          = ADDR_W_DEFAULT,
    parameter int LOAD_EX_STALLS  = 2,
    parameter int LOAD_MEM_STALLS = 1
) (
    input  logic                  clk,
    input  logic                  rst_n,
    branch_hazard_ctrl_if.slave   bus
`ifdef BRANCH_HAZARD_STATS_EN
    ,
    output logic [15:0]           stall_count,
    output logic [15:0]           taken_count
`endif
);

    localparam logic [1:0] EX_CNT  = stall_cnt_init(LOAD_EX_STALLS);
    localparam logic [1:0] MEM_CNT = stall_cnt_init(LOAD_MEM_STALLS);

    state_t     state_q, state_d;
    logic [1:0] cnt_q, cnt_d;
    logic       hz_ex, hz_mem, taken;
    logic       stall, redirect;

    branch_hazard_ctrl_hazard_match #(.ADDR_W(ADDR_W)) u_match_ex (
        .branch    (bus.branch_ID),
        .reg_write (bus.regWrite_EX),
        .mem_read  (bus.memRead_EX),
        .wr_addr   (bus.regFileWriteAddr_EX),
        .rs        (bus.rs_ID),
        .rt        (bus.rt_ID),
        .hit       (hz_ex)
    );

    branch_hazard_ctrl_hazard_match #(.ADDR_W(ADDR_W)) u_match_mem (
        .branch    (bus.branch_ID),
        .reg_write (bus.regWrite_MEM),
        .mem_read  (bus.memRead_MEM),
        .wr_addr   (bus.regFileWriteAddr_MEM),
        .rs        (bus.rs_ID),
        .rt        (bus.rt_ID),
        .hit       (hz_mem)
    );

    assign taken = bus.branch_ID & (bus.regEqulityC ^ bus.branch_ne_ID);

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        stall    = 1'b0;
        redirect = 1'b0;
        case (state_q)
            IDLE: begin
                // EX is checked first: an EX load is younger and needs the longer wait.
                if (hz_ex) begin
                    stall   = 1'b1;
                    cnt_d   = EX_CNT;
                    state_d = (EX_CNT == 2'd0) ? RESOLVE : STALL;
                end else if (hz_mem) begin
                    stall   = 1'b1;
                    cnt_d   = MEM_CNT;
                    state_d = (MEM_CNT == 2'd0) ? RESOLVE : STALL;
                end else begin
                    redirect = taken;
                end
            end
            STALL: begin
                // cnt counts stall cycles still owed including this one, so the
                // detection cycle plus the STALL cycles add up to the configured total.
                stall = 1'b1;
                if (cnt_q <= 2'd1) begin
                    cnt_d   = 2'd0;
                    state_d = RESOLVE;
                end else begin
                    cnt_d = cnt_q - 2'd1;
                end
            end
            RESOLVE: begin
                // taken already folds in branch_ID, so a vanished branch resolves to 0.
                redirect = taken;
                state_d  = IDLE;
            end
            default: begin
                state_d = IDLE;
                cnt_d   = 2'd0;
            end
        endcase
        if (!rst_n) begin
            stall    = 1'b0;
            redirect = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= IDLE;
            cnt_q   <= 2'd0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    assign bus.stall_PC    = stall;
    assign bus.stall_IFID  = stall;
    assign bus.bubble_IDEX = stall;
    assign bus.pcSrc       = redirect;
    assign bus.flush_IFID  = redirect;

`ifdef BRANCH_HAZARD_STATS_EN
    logic [15:0] stall_count_q, stall_count_d;
    logic [15:0] taken_count_q, taken_count_d;

    always_comb begin
        stall_count_d = stall_count_q;
        taken_count_d = taken_count_q;
        if (stall && (stall_count_q != 16'hFFFF)) begin
            stall_count_d = stall_count_q + 16'd1;
        end
        if (redirect && (taken_count_q != 16'hFFFF)) begin
            taken_count_d = taken_count_q + 16'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            stall_count_q <= 16'd0;
            taken_count_q <= 16'd0;
        end else begin
            stall_count_q <= stall_count_d;
            taken_count_q <= taken_count_d;
        end
    end

    assign stall_count = stall_count_q;
    assign taken_count = taken_count_q;
`endif

endmodule
